tri_raster: RTL and testbench

TRI_RASTER -- requirements
Module: tri_raster

---
 rtl/tri_raster.sv | 212 +++++++++++++++++++++
 tb/tb_tri_raster.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_raster.sv
// Triangle rasteriser: captures three vertices, then scans the bounding box in raster
// order and emits the grid points whose three edge functions agree in sign.
// Optional macro TRI_RASTER_CNT_EN adds the transferred-point counter output cnt.
module tri_raster #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nt,
    input  logic [CW-1:0] xi,
    input  logic [CW-1:0] yi,
    input  logic          rdy,
    output logic          busy,
    output logic          po,
    output logic [CW-1:0] xo,
    output logic [CW-1:0] yo,
    output logic          done
`ifdef TRI_RASTER_CNT_EN
    ,
    output logic [2*CW:0] cnt
`endif
);

    localparam int EW = 2*CW + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD1,
        S_LOAD2,
        S_SETUP,
        S_SCAN,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
    logic [CW-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [CW-1:0] r_cx, r_cy;
    logic          r_exhausted;
    logic          r_busy, r_po, r_done;
    logic [CW-1:0] r_xo, r_yo;

    logic [CW-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [EW-1:0] w_e0, w_e1, w_e2;
    logic                 w_inside, w_last, w_adv, w_to_fin;

    function automatic logic signed [EW-1:0] zext(input logic [CW-1:0] v);
        return $signed({{(EW-CW){1'b0}}, v});
    endfunction

    // Widened to EW bits so neither the differences nor the products can overflow.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CW-1:0] xa, input logic [CW-1:0] ya,
        input logic [CW-1:0] xb, input logic [CW-1:0] yb,
        input logic [CW-1:0] px, input logic [CW-1:0] py
    );
        logic signed [EW-1:0] dxe, dye, dxp, dyp;
        dxe = zext(xb) - zext(xa);
        dye = zext(yb) - zext(ya);
        dxp = zext(px) - zext(xa);
        dyp = zext(py) - zext(ya);
        return dxe*dyp - dye*dxp;
    endfunction

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign w_xmin = min3(r_x0, r_x1, r_x2);
    assign w_xmax = max3(r_x0, r_x1, r_x2);
    assign w_ymin = min3(r_y0, r_y1, r_y2);
    assign w_ymax = max3(r_y0, r_y1, r_y2);

    assign w_e0 = edge_fn(r_x0, r_y0, r_x1, r_y1, r_cx, r_cy);
    assign w_e1 = edge_fn(r_x1, r_y1, r_x2, r_y2, r_cx, r_cy);
    assign w_e2 = edge_fn(r_x2, r_y2, r_x0, r_y0, r_cx, r_cy);

    // Inclusive on edges and winding-agnostic; degenerate shapes keep only all-zero points.
    assign w_inside = ((w_e0 >= 0) && (w_e1 >= 0) && (w_e2 >= 0)) ||
                      ((w_e0 <= 0) && (w_e1 <= 0) && (w_e2 <= 0));
    assign w_last   = (r_cx == r_xmax) && (r_cy == r_ymax);
    assign w_adv    = !r_po || rdy;
    assign w_to_fin = (r_state == S_SCAN) && (w_state_next == S_FIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (nt) w_state_next = S_LOAD1;
            S_LOAD1: w_state_next = S_LOAD2;
            S_LOAD2: w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_SCAN;
            S_SCAN: begin
                if (w_adv && (r_exhausted || (w_last && !w_inside))) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Vertex, bounding-box and scan-position registers carry no reset value.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (nt) begin
                    r_x0 <= xi;
                    r_y0 <= yi;
                end
            end
            S_LOAD1: begin
                r_x1 <= xi;
                r_y1 <= yi;
            end
            S_LOAD2: begin
                r_x2 <= xi;
                r_y2 <= yi;
            end
            S_SETUP: begin
                r_xmin      <= w_xmin;
                r_xmax      <= w_xmax;
                r_ymin      <= w_ymin;
                r_ymax      <= w_ymax;
                r_cx        <= w_xmin;
                r_cy        <= w_ymin;
                r_exhausted <= 1'b0;
            end
            S_SCAN: begin
                if (w_adv && !r_exhausted) begin
                    if (w_last) begin
                        r_exhausted <= w_inside;
                    end else if (r_cx == r_xmax) begin
                        r_cx <= r_xmin;
                        r_cy <= r_cy + CW'(1);
                    end else begin
                        r_cx <= r_cx + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_po   <= 1'b0;
            r_done <= 1'b0;
            r_xo   <= '0;
            r_yo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_LOAD2) begin
                r_busy <= 1'b1;
            end
            if (w_to_fin) begin
                r_po   <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else if (r_state == S_SCAN && w_adv) begin
                r_po <= w_inside;
                if (w_inside) begin
                    r_xo <= r_cx;
                    r_yo <= r_cy;
                end
            end
        end
    end

`ifdef TRI_RASTER_CNT_EN
    logic [2*CW:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && nt) begin
            r_cnt <= '0;
        end else if (r_po && rdy) begin
            r_cnt <= r_cnt + (2*CW+1)'(1);
        end
    end

    assign cnt = r_cnt;
`endif

    assign busy = r_busy;
    assign po   = r_po;
    assign xo   = r_xo;
    assign yo   = r_yo;
    assign done = r_done;

endmodule

// File: tb/tb_tri_raster.sv
// Directed bench for tri_raster (CW=3): right triangle both windings, degenerate shapes,
// backpressure, nt while busy, mid-scan reset and back-to-back triangles.
module tb_tri_raster;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          nt;
    logic [CW-1:0] xi, yi;
    logic          rdy;
    logic          busy, po, done;
    logic [CW-1:0] xo, yo;
`ifdef TRI_RASTER_CNT_EN
    logic [2*CW:0] cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int px_q[$], py_q[$], sx_q[$], sy_q[$];
    int ex_x[$], ex_y[$];

    always #5 clk = ~clk;

    tri_raster #(.CW(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .nt   (nt),
        .xi   (xi),
        .yi   (yi),
        .rdy  (rdy),
        .busy (busy),
        .po   (po),
        .xo   (xo),
        .yo   (yo),
        .done (done)
`ifdef TRI_RASTER_CNT_EN
        ,
        .cnt  (cnt)
`endif
    );

    task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        @(negedge clk); nt = 1'b1; xi = CW'(x0); yi = CW'(y0);
        @(negedge clk); nt = 1'b0; xi = CW'(x1); yi = CW'(y1);
        @(negedge clk); xi = CW'(x2); yi = CW'(y2);
        @(negedge clk); xi = '0; yi = '0;
    endtask

    // Runs until done (or stop_after transfers); rdy is decided at each negedge for the next edge.
    task automatic collect(input int stall_n, input int nt_at, input int stop_after,
                           output int first_po, output bit timed_out);
        int stall_left;
        stall_left = stall_n;
        px_q.delete(); py_q.delete(); sx_q.delete(); sy_q.delete();
        first_po  = -1;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                nt = 1'b0; rdy = 1'b1; timed_out = 1'b0;
                return;
            end
            nt = (c == nt_at);
            xi = (c == nt_at) ? CW'(7) : '0;
            yi = '0;
            rdy = 1'b1;
            if (po) begin
                if (first_po < 0) first_po = c;
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                    sx_q.push_back(int'(xo));
                    sy_q.push_back(int'(yo));
                end else begin
                    px_q.push_back(int'(xo));
                    py_q.push_back(int'(yo));
                    if (stop_after > 0 && px_q.size() == stop_after) begin
                        timed_out = 1'b0;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic check_timeout(input string name, input bit timed_out);
        n_vec++;
        if (timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s: no done within cycle budget (timed_out=%0d, required 0)", name, timed_out);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; nt = 1'b0; rdy = 1'b1; xi = '0; yi = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, po, done, xo, yo} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b po=%b done=%b xo=%0d yo=%0d, required all 0",
                     busy, po, done, xo, yo);
        end
`ifdef TRI_RASTER_CNT_EN
        n_vec++;
        if (cnt !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: cnt=%0d, required 0", cnt);
        end
`endif
        reset = 1'b1;
        $display("test_reset: reset state checked");
    endtask

    task automatic check_seq(input string name);
        n_vec++;
        if (px_q.size() !== ex_x.size()) begin
            n_err++;
            $display("FAIL %s_count: %0d points, required %0d", name, px_q.size(), ex_x.size());
        end else begin
            for (int i = 0; i < ex_x.size(); i++) begin
                n_vec++;
                if (px_q[i] !== ex_x[i] || py_q[i] !== ex_y[i]) begin
                    n_err++;
                    $display("FAIL %s_pt%0d: (%0d,%0d), required (%0d,%0d)",
                             name, i, px_q[i], py_q[i], ex_x[i], ex_y[i]);
                end
            end
        end
    endtask

    task automatic check_end(input string name, input int exp_cnt);
        n_vec++;
        if (busy !== 1'b0 || po !== 1'b0) begin
            n_err++;
            $display("FAIL %s_fin: busy=%b po=%b at done, required 0 0", name, busy, po);
        end
`ifdef TRI_RASTER_CNT_EN
        n_vec++;
        if (cnt !== (2*CW+1)'(exp_cnt)) begin
            n_err++;
            $display("FAIL %s_cnt: cnt=%0d, required %0d", name, cnt, exp_cnt);
        end
`endif
    endtask

    task automatic build_right;
        ex_x.delete(); ex_y.delete();
        for (int y = 1; y <= 5; y++)
            for (int x = y; x <= 5; x++) begin
                ex_x.push_back(x);
                ex_y.push_back(y);
            end
    endtask

    task automatic test_right;
        int fp; bit to;
        build_right();
        send_tri(1, 1, 5, 1, 5, 5);
        collect(0, -1, 0, fp, to);
        check_timeout("right", to);
        check_seq("right");
        check_end("right", 15);
        n_vec++;
        if (fp < 1) begin
            n_err++;
            $display("FAIL right_latency: first po at cycle %0d, required >= 1", fp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL right_done_once: done=%b %0d cycles after pulse, required 0", done, i + 1);
            end
        end
        $display("test_right: %0d points", px_q.size());
    endtask

    task automatic test_reverse;
        int fp; bit to;
        build_right();
        send_tri(1, 1, 5, 5, 5, 1);
        collect(0, -1, 0, fp, to);
        check_timeout("reverse", to);
        check_seq("reverse");
        check_end("reverse", 15);
        $display("test_reverse: %0d points", px_q.size());
    endtask

    task automatic test_point;
        int fp; bit to;
        ex_x = '{2}; ex_y = '{3};
        send_tri(2, 3, 2, 3, 2, 3);
        collect(0, -1, 0, fp, to);
        check_timeout("point", to);
        check_seq("point");
        check_end("point", 1);
        $display("test_point: %0d points", px_q.size());
    endtask

    task automatic test_backpressure;
        int fp; bit to;
        build_right();
        send_tri(1, 1, 5, 1, 5, 5);
        collect(3, -1, 0, fp, to);
        check_timeout("bp", to);
        n_vec++;
        if (sx_q.size() !== 3) begin
            n_err++;
            $display("FAIL bp_stalls: %0d stalled cycles seen, required 3", sx_q.size());
        end
        for (int i = 0; i < sx_q.size(); i++) begin
            n_vec++;
            if (sx_q[i] !== 1 || sy_q[i] !== 1) begin
                n_err++;
                $display("FAIL bp_hold%0d: (%0d,%0d), required (1,1)", i, sx_q[i], sy_q[i]);
            end
        end
        check_seq("bp");
        check_end("bp", 15);
        $display("test_backpressure: %0d points", px_q.size());
    endtask

    task automatic test_nt_busy;
        int fp; bit to;
        build_right();
        send_tri(1, 1, 5, 1, 5, 5);
        collect(0, 5, 0, fp, to);
        check_timeout("ntbusy", to);
        check_seq("ntbusy");
        check_end("ntbusy", 15);
        $display("test_nt_busy: %0d points", px_q.size());
    endtask

    task automatic test_reset_mid;
        int fp; bit to;
        build_right();
        send_tri(1, 1, 5, 1, 5, 5);
        collect(0, -1, 4, fp, to);
        check_timeout("rstmid_run", to);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy: busy=%b before reset, required 1", busy);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (po !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: po=%b busy=%b done=%b, required 0 0 0", po, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (po !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_quiet%0d: po=%b done=%b, required 0 0", i, po, done);
            end
        end
        reset = 1'b1;
        send_tri(1, 1, 5, 1, 5, 5);
        collect(0, -1, 0, fp, to);
        check_timeout("rstmid_rerun", to);
        check_seq("rstmid_rerun");
        check_end("rstmid_rerun", 15);
        $display("test_reset_mid: rerun %0d points", px_q.size());
    endtask

    task automatic test_back_to_back;
        int fp; bit to;
        send_tri(4, 0, 4, 0, 4, 0);
        collect(0, -1, 0, fp, to);
        check_timeout("b2b_first", to);
        // nt goes out in the cycle right after done
        ex_x = '{0, 1, 2}; ex_y = '{0, 1, 2};
        send_tri(0, 0, 2, 2, 1, 1);
        collect(0, -1, 0, fp, to);
        check_timeout("b2b_second", to);
        check_seq("b2b_collinear");
        check_end("b2b_collinear", 3);
        $display("test_back_to_back: %0d points", px_q.size());
    endtask

    initial begin
        test_reset();
        test_right();
        test_reverse();
        test_point();
        test_backpressure();
        test_nt_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
